i2s_master_gen: RTL

Parametrised I2S master transmitter; the successor to the fixed 16-bit master with its separate bit-clock generator.
- Generates BCLK internally from the system clock; no external BCLK input.
- Buffers stereo sample pairs in a small FIFO behind a valid/ready handshake.
- Supports I2S, left-justified and right-justified framing, with configurable data and slot widths.
- Sits between an audio sample source (switch board, tone generator, DMA) and the codec pins.

---
 rtl/i2s_master_gen.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/i2s_master_gen.sv
// I2S / left- / right-justified master transmitter: internal BCLK divider, sample-pair FIFO, registered pin outputs.
// Optional I2S_HOLD_LAST_EN: on underrun re-send the last transmitted pair instead of zeros.
module i2s_master_gen #(
  parameter int DATA_W     = 16,
  parameter int SLOT_W     = 32,
  parameter int CLK_DIV    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [1:0]                  mode,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_left,
  input  logic [DATA_W-1:0]           s_right,
  output logic                        BCLK,
  output logic                        LRCLK,
  output logic                        SDATA,
  output logic                        RightNLeft,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int FRAME = 2 * SLOT_W;
  localparam int BW    = $clog2(FRAME);
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [1:0] MODE_LJ = 2'b01;
  localparam logic [1:0] MODE_RJ = 2'b10;

  logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [DW-1:0]     div_cnt;
  logic [BW-1:0]     bit_cnt, bit_nxt;
  logic              active;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] cur_l, cur_r, ld_l, ld_r;
  logic              fall_tick, load, pop, push;

  // Wire value of frame bit n for a given pair and framing mode.
  function automatic logic slot_bit(input int n, input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                                    input logic [1:0] m);
    int k, idx;
    logic [DATA_W-1:0] d, sh;
    d   = (n >= SLOT_W) ? r : l;
    k   = (n >= SLOT_W) ? n - SLOT_W : n;
    idx = (m == MODE_RJ) ? SLOT_W - 1 - k : DATA_W - 1 - k;
    sh  = d >> idx;
    return (idx >= 0 && idx < DATA_W) ? sh[0] : 1'b0;
  endfunction

  // I2S word select leads the data by one bit; the justified modes track the data channel.
  function automatic logic ws_bit(input int n, input logic [1:0] m);
    if (m == MODE_LJ || m == MODE_RJ) return n >= SLOT_W;
    return ((n + 1) % FRAME) >= SLOT_W;
  endfunction

  assign s_ready   = (fifo_level != LW'(FIFO_DEPTH));
  assign push      = s_valid && s_ready;
  assign fall_tick = active && BCLK && (div_cnt == DW'(CLK_DIV - 1));
  assign load      = en && (!active || (fall_tick && bit_cnt == BW'(FRAME - 1)));
  assign pop       = load && (fifo_level != '0);
  assign bit_nxt   = bit_cnt + 1'b1;

`ifdef I2S_HOLD_LAST_EN
  logic [DATA_W-1:0] hold_l, hold_r;

  assign ld_l = pop ? mem_l[rd_ptr] : hold_l;
  assign ld_r = pop ? mem_r[rd_ptr] : hold_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (pop) begin
      hold_l <= mem_l[rd_ptr];
      hold_r <= mem_r[rd_ptr];
    end
  end
`else
  assign ld_l = pop ? mem_l[rd_ptr] : '0;
  assign ld_r = pop ? mem_r[rd_ptr] : '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      active     <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      mode_q     <= '0;
      cur_l      <= '0;
      cur_r      <= '0;
      BCLK       <= 1'b0;
      LRCLK      <= 1'b0;
      SDATA      <= 1'b0;
      RightNLeft <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (push) begin
        mem_l[wr_ptr] <= s_left;
        mem_r[wr_ptr] <= s_right;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;

      if (!en) begin
        active     <= 1'b0;
        div_cnt    <= '0;
        bit_cnt    <= '0;
        BCLK       <= 1'b0;
        LRCLK      <= 1'b0;
        SDATA      <= 1'b0;
        RightNLeft <= 1'b0;
        underrun   <= 1'b0;
      end else if (load) begin
        // Bit 0 of the new frame goes out now; BCLK rises CLK_DIV cycles later.
        active     <= 1'b1;
        div_cnt    <= '0;
        bit_cnt    <= '0;
        BCLK       <= 1'b0;
        cur_l      <= ld_l;
        cur_r      <= ld_r;
        mode_q     <= mode;
        SDATA      <= slot_bit(0, ld_l, ld_r, mode);
        LRCLK      <= ws_bit(0, mode);
        RightNLeft <= 1'b0;
        if (!pop) underrun <= 1'b1;
      end else begin
        if (div_cnt == DW'(CLK_DIV - 1)) begin
          div_cnt <= '0;
          BCLK    <= ~BCLK;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        if (fall_tick) begin
          bit_cnt    <= bit_nxt;
          SDATA      <= slot_bit(int'(bit_nxt), cur_l, cur_r, mode_q);
          LRCLK      <= ws_bit(int'(bit_nxt), mode_q);
          RightNLeft <= (bit_nxt >= BW'(SLOT_W));
        end
      end
    end
  end
endmodule
